// File: rtl/compare_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// compare_pkg : shared FSM states and one-hot result encoding  | rev 1.0
// ---------------------------------------------------------------------------
package compare_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Result vector bit order is {lt, eq, gt}
  localparam logic [2:0] RES_LT = 3'b100;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_GT = 3'b001;

endpackage
`default_nettype wire

// File: rtl/serial_cmp_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_cmp_engine : MSB-first bit-serial magnitude compare, early exit | rev 1.0
// ---------------------------------------------------------------------------
module serial_cmp_engine
  import compare_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         done,
  output logic [2:0]   res
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_msb, b_msb;

  assign a_msb = a_sh_q[W-1];
  assign b_msb = b_sh_q[W-1];

  // Finished once the MSBs disagree or the last bit has been examined
  assign done = (a_msb != b_msb) || (cnt_q == '0);

  always_comb begin
    res = RES_EQ;
    if (a_msb && !b_msb) begin
      res = RES_GT;
    end else if (!a_msb && b_msb) begin
      res = RES_LT;
    end
  end

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;
    if (load) begin
      a_sh_d = a_in;
      b_sh_d = b_in;
      cnt_d  = CW'(W - 1);
    end else if (step && !done) begin
      a_sh_d = {a_sh_q[W-2:0], 1'b0};
      b_sh_d = {b_sh_q[W-2:0], 1'b0};
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/compare_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// compare_scheduler : round-robin arbiter sharing one serial comparator | rev 1.0
// ---------------------------------------------------------------------------
module compare_scheduler
  import compare_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_lt,
  output logic               rsp_eq,
  output logic               rsp_gt,
  output logic               busy
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [2:0]      rsp_res_q, rsp_res_d;
  logic            busy_q, busy_d;

  logic [ID_W-1:0] winner;
  logic            any_valid;
  logic [ID_W:0]   rr_idx;
  logic [W-1:0]    sel_a, sel_b;
  logic            eng_load, eng_step, eng_done;
  logic [2:0]      eng_res;

  // Walk farthest-to-nearest so the index right after last_grant wins
  always_comb begin
    winner    = last_grant_q;
    any_valid = 1'b0;
    rr_idx    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      rr_idx = {1'b0, last_grant_q} + (ID_W+1)'(off);
      if (rr_idx >= (ID_W+1)'(N_REQ)) begin
        rr_idx = rr_idx - (ID_W+1)'(N_REQ);
      end
      if (req_valid[rr_idx[ID_W-1:0]]) begin
        winner    = rr_idx[ID_W-1:0];
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && any_valid) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  serial_cmp_engine #(.W(W)) u_engine (
    .clk   (clk),
    .reset (reset),
    .load  (eng_load),
    .step  (eng_step),
    .a_in  (sel_a),
    .b_in  (sel_b),
    .done  (eng_done),
    .res   (eng_res)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_res_d    = rsp_res_q;
    eng_load     = 1'b0;
    eng_step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          eng_load = 1'b1;
          id_d     = winner;
          state_d  = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        eng_step = 1'b1;
        if (eng_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Engine is frozen here, so its flags still hold the final verdict
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_res_d    = eng_res;
        last_grant_d = id_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_res_q    <= RES_EQ;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_res_q    <= rsp_res_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_lt    = rsp_res_q[2];
  assign rsp_eq    = rsp_res_q[1];
  assign rsp_gt    = rsp_res_q[0];
  assign busy      = busy_q;

endmodule
`default_nettype wire
